// File: rtl/ex_divider_pkg.sv
// Shared core definitions: divide/remainder op encodings (aluop[1:0]) and
// the divider FSM state type.
package ex_divider_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   function automatic logic is_signed_op(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_rem_op(input logic [1:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/ex_divider_if.sv
// Request/response bundle between the pipeline (master) and the divider (slave).
interface ex_divider_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero_division;
   logic             overflow_signed_div;

   modport master (
      output start, a, b, op, flush,
      input  busy, done, result, zero_division, overflow_signed_div
   );

   modport slave (
      input  start, a, b, op, flush,
      output busy, done, result, zero_division, overflow_signed_div
   );
endinterface

// File: rtl/ex_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);
   logic [WIDTH:0] partial;
   logic [WIDTH:0] diff;

   // Trial subtraction one bit wider than the operands so the borrow is visible.
   always_comb begin
      partial = {rem_i, bit_i};
      diff    = partial - {1'b0, divisor_i};
      qbit_o  = ~diff[WIDTH];
      rem_o   = qbit_o ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
   end
endmodule

// File: rtl/ex_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, sign fix-up at completion, single-cycle special cases.
module ex_divider
   import ex_divider_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic        clk,
   input logic        rst_n,
   ex_divider_if.slave bus
);
   localparam int unsigned    CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] ZERO    = '0;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e       state_q;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       op_q;
   logic             neg_quo_q, neg_rem_q;
   logic [WIDTH-1:0] dvsr_q, rem_q, quo_q;
   logic             busy_q, done_q, zdiv_q, ovf_q;
   logic [WIDTH-1:0] result_q;

   logic             a_neg_d, b_neg_d, b_zero_d, ovf_d;
   logic [WIDTH-1:0] a_mag_d, b_mag_d, special_d;
   logic [WIDTH-1:0] step_rem, quo_fin_d, final_d;
   logic             step_qbit;

   // Decode the incoming request: magnitudes, signs and single-cycle results.
   always_comb begin
      a_neg_d   = is_signed_op(bus.op) & bus.a[WIDTH-1];
      b_neg_d   = is_signed_op(bus.op) & bus.b[WIDTH-1];
      a_mag_d   = a_neg_d ? (ZERO - bus.a) : bus.a;
      b_mag_d   = b_neg_d ? (ZERO - bus.b) : bus.b;
      b_zero_d  = (bus.b == ZERO);
      ovf_d     = is_signed_op(bus.op) && (bus.a == MIN_NEG) && (bus.b == '1);
      if (is_rem_op(bus.op)) special_d = b_zero_d ? bus.a : ZERO;
      else                   special_d = b_zero_d ? '1    : MIN_NEG;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .bit_i     (quo_q[WIDTH-1]),
      .divisor_i (dvsr_q),
      .rem_o     (step_rem),
      .qbit_o    (step_qbit)
   );

   // Sign fix-up applied to the outcome of the last CALC step.
   always_comb begin
      quo_fin_d = {quo_q[WIDTH-2:0], step_qbit};
      if (is_rem_op(op_q)) final_d = neg_rem_q ? (ZERO - step_rem) : step_rem;
      else                 final_d = neg_quo_q ? (ZERO - quo_fin_d) : quo_fin_d;
   end

   // Control FSM and datapath registers; flush overrides everything but reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dvsr_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         zdiv_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (bus.flush) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  op_q      <= bus.op;
                  neg_quo_q <= a_neg_d ^ b_neg_d;
                  neg_rem_q <= a_neg_d;
                  dvsr_q    <= b_mag_d;
                  quo_q     <= a_mag_d;
                  rem_q     <= '0;
                  busy_q    <= 1'b1;
                  if (b_zero_d || ovf_d) begin
                     state_q  <= ST_DONE;
                     cnt_q    <= '0;
                     done_q   <= 1'b1;
                     result_q <= special_d;
                     zdiv_q   <= b_zero_d;
                     ovf_q    <= ovf_d;
                  end else begin
                     state_q <= ST_CALC;
                     cnt_q   <= CW'(WIDTH - 1);
                  end
               end
            end
            ST_CALC: begin
               rem_q <= step_rem;
               quo_q <= quo_fin_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_q  <= ST_DONE;
                  done_q   <= 1'b1;
                  result_q <= final_d;
                  zdiv_q   <= 1'b0;
                  ovf_q    <= 1'b0;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy                = busy_q;
   assign bus.done                = done_q;
   assign bus.result              = result_q;
   assign bus.zero_division       = zdiv_q;
   assign bus.overflow_signed_div = ovf_q;

endmodule

// File: tb/tb_ex_divider.sv
// Directed bench for ex_divider (WIDTH=32) with hand-computed expectations.
module tb_ex_divider;
   import ex_divider_pkg::*;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   cyc;
   int   t0;
   int   done_cnt;
   int   snap;
   bit   seen;

   ex_divider_if #(.WIDTH(32)) bus ();

   ex_divider #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Count every observed done cycle, sampled away from the active edge.
   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request for exactly one rising edge; t0 marks the edge count before it.
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      t0        = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output bit got);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.done === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_done(input string tag, input logic [31:0] exp_res,
                             input logic exp_z, input logic exp_o, input int exp_lat);
      check({tag, " done"},    {31'd0, seen}, 32'd1);
      check({tag, " latency"}, cyc - t0, exp_lat);
      check({tag, " result"},  bus.result, exp_res);
      check({tag, " zdiv"},    {31'd0, bus.zero_division}, {31'd0, exp_z});
      check({tag, " ovf"},     {31'd0, bus.overflow_signed_div}, {31'd0, exp_o});
      check({tag, " busy"},    {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      check({tag, " pulse"},   {31'd0, bus.done}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_z, input logic exp_o, input int exp_lat);
      launch(op, a, b);
      wait_done(seen);
      check_done(tag, exp_res, exp_z, exp_o, exp_lat);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      done_cnt  = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = OP_DIV;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check("rst busy",   {31'd0, bus.busy}, 32'd0);
      check("rst done",   {31'd0, bus.done}, 32'd0);
      check("rst result", bus.result, 32'd0);
      check("rst zdiv",   {31'd0, bus.zero_division}, 32'd0);
      check("rst ovf",    {31'd0, bus.overflow_signed_div}, 32'd0);
      rst_n = 1'b1;

      run_op("div -7/2",     OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, 33);
      run_op("rem -7/2",     OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, 33);
      run_op("remu big/2",   OP_REMU, 32'hFFFFFFF9, 32'd2,        32'h00000001, 1'b0, 1'b0, 33);
      run_op("divu 100/0",   OP_DIVU, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 1);
      run_op("remu 100/0",   OP_REMU, 32'd100,      32'd0,        32'd100,      1'b1, 1'b0, 1);
      run_op("div ovf",      OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1);
      run_op("rem ovf",      OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1);
      run_op("div 100/-7",   OP_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 1'b0, 33);
      run_op("rem 100/-7",   OP_REM,  32'd100,      32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, 33);
      run_op("rem -100/7",   OP_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 33);
      run_op("div min/1",    OP_DIV,  32'h80000000, 32'd1,        32'h80000000, 1'b0, 1'b0, 33);
      run_op("div -5/0",     OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 1);
      run_op("rem -5/0",     OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1, 1'b0, 1);
      run_op("divu max/1",   OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 33);
      run_op("divu min/max", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 33);
      run_op("remu min/max", OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 33);

      // Second start while busy must be neither merged nor queued.
      launch(OP_DIVU, 32'd20, 32'd6);
      repeat (4) @(negedge clk);
      bus.op    = OP_DIV;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(seen);
      check_done("busy start", 32'd3, 1'b0, 1'b0, 33);
      snap = done_cnt;
      repeat (40) @(negedge clk);
      check("busy no queue", done_cnt - snap, 32'd0);
      check("busy idle",     {31'd0, bus.busy}, 32'd0);

      // Flush ten cycles into CALC.
      launch(OP_DIVU, 32'd1000, 32'd3);
      snap = done_cnt;
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush busy",   {31'd0, bus.busy}, 32'd0);
      check("flush done",   {31'd0, bus.done}, 32'd0);
      check("flush hold",   bus.result, 32'd3);
      repeat (40) @(negedge clk);
      check("flush nodone", done_cnt - snap, 32'd0);
      run_op("divu 7/3 after flush", OP_DIVU, 32'd7, 32'd3, 32'd2, 1'b0, 1'b0, 33);

      // Asynchronous reset mid-CALC.
      launch(OP_DIVU, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst busy",   {31'd0, bus.busy}, 32'd0);
      check("arst done",   {31'd0, bus.done}, 32'd0);
      check("arst result", bus.result, 32'd0);
      check("arst zdiv",   {31'd0, bus.zero_division}, 32'd0);
      check("arst ovf",    {31'd0, bus.overflow_signed_div}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      snap  = done_cnt;
      repeat (40) @(negedge clk);
      check("arst nodone", done_cnt - snap, 32'd0);
      check("arst idle",   {31'd0, bus.busy}, 32'd0);
      run_op("divu 7/3 after reset", OP_DIVU, 32'd7, 32'd3, 32'd2, 1'b0, 1'b0, 33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
